// File: rtl/sliding_window_buffer.sv
// Circular word buffer: fixed-width pushes of WRITE_SIZE words, a READ_SIZE-word
// window presented from the read pointer, and consumes of a variable stride.
module sliding_window_buffer #(
    parameter int SIZE       = 16,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     in [0:WRITE_SIZE-1],
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out [0:READ_SIZE-1],
    output logic                      out_valid,
    input  logic                      read_en,
    input  logic [$clog2(READ_SIZE):0] read_stride,
    input  logic                      flush,
    output logic [$clog2(SIZE):0]     count
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(READ_SIZE) + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [0:SIZE-1];
    logic [DATA_WIDTH-1:0] mem_d [0:SIZE-1];

    logic [SW-1:0] stride;
    logic          push;
    logic          pop;

    // Flow control looks only at registered occupancy; a same-cycle pop gives no credit.
    assign in_ready  = (CW'(SIZE) - count_q) >= CW'(WRITE_SIZE);
    assign out_valid = count_q >= CW'(READ_SIZE);
    assign count     = count_q;

    assign stride = (read_stride > SW'(READ_SIZE)) ? SW'(READ_SIZE) : read_stride;
    assign push   = in_valid & in_ready;
    assign pop    = read_en & out_valid;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Storage is deliberately kept; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                for (int j = 0; j < WRITE_SIZE; j++) begin
                    mem_d[wr_ptr_q + AW'(j)] = in[j];
                end
                wr_ptr_d = wr_ptr_q + AW'(WRITE_SIZE);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(stride);
            end
            count_d = count_q + (push ? CW'(WRITE_SIZE) : CW'(0))
                              - (pop  ? CW'(stride)     : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Window taps wrap naturally through the AW-bit pointer addition.
    for (genvar k = 0; k < READ_SIZE; k++) begin : g_tap
        assign out[k] = mem_q[rd_ptr_q + AW'(k)];
    end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Scoreboard bench: driver issues one transaction per cycle and queues the expected
// post-edge view; a monitor pops and compares one entry per rising edge.
module tb_sliding_window_buffer;

    localparam int SZ = 8;
    localparam int WS = 2;
    localparam int RS = 3;

    logic       clk;
    logic       rst;
    logic [7:0] din [0:WS-1];
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout [0:RS-1];
    logic       out_valid;
    logic       read_en;
    logic [2:0] read_stride;
    logic       flush;
    logic [3:0] count;

    sliding_window_buffer #(
        .SIZE(SZ), .WRITE_SIZE(WS), .READ_SIZE(RS), .DATA_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .out(dout), .out_valid(out_valid), .read_en(read_en),
        .read_stride(read_stride), .flush(flush), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit rdy;
        bit vld;
        int w [RS];
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a plain address-indexed image plus occupancy arithmetic.
    int m_mem [SZ];
    int m_wp, m_rp, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit iv, input int d0, input int d1,
                              input bit re, input int st, input bit fl);
        int s;
        bit do_push, do_pop;
        if (!r) begin
            for (int i = 0; i < SZ; i++) m_mem[i] = 0;
            m_wp = 0; m_rp = 0; m_cnt = 0;
        end else if (fl) begin
            m_wp = 0; m_rp = 0; m_cnt = 0;
        end else begin
            s       = (st > RS) ? RS : st;
            do_push = iv && (SZ - m_cnt >= WS);
            do_pop  = re && (m_cnt >= RS);
            if (do_push) begin
                m_mem[m_wp % SZ]       = d0;
                m_mem[(m_wp + 1) % SZ] = d1;
                m_wp = (m_wp + WS) % SZ;
            end
            if (do_pop) m_rp = (m_rp + s) % SZ;
            m_cnt = m_cnt + (do_push ? WS : 0) - (do_pop ? s : 0);
        end
    endtask

    task automatic cycle(input bit r, input bit iv, input int d0, input int d1,
                         input bit re, input int st, input bit fl);
        exp_t e;
        @(negedge clk);
        rst         = r;
        in_valid    = iv;
        din[0]      = d0[7:0];
        din[1]      = d1[7:0];
        read_en     = re;
        read_stride = st[2:0];
        flush       = fl;
        model_step(r, iv, d0 & 255, d1 & 255, re, st & 7, fl);
        e.cnt = m_cnt;
        e.rdy = (SZ - m_cnt) >= WS;
        e.vld = m_cnt >= RS;
        for (int k = 0; k < RS; k++) e.w[k] = m_mem[(m_rp + k) % SZ];
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("in_ready", int'(in_ready), int'(e.rdy));
                chk("out_valid", int'(out_valid), int'(e.vld));
                for (int k = 0; k < RS; k++) chk($sformatf("out%0d", k), int'(dout[k]), e.w[k]);
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; read_en = 1'b0; read_stride = '0; flush = 1'b0;
        din[0] = '0; din[1] = '0;
        for (int i = 0; i < SZ; i++) m_mem[i] = 0;
        m_wp = 0; m_rp = 0; m_cnt = 0;

        // Reset held two cycles
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        settle();
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Two pushes then a same-cycle pop(1)+push
        cycle(1'b1, 1'b1, 11, 12, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 13, 14, 1'b0, 0, 1'b0);
        settle();
        chk("fill4_count", int'(count), 4);
        chk("fill4_out0", int'(dout[0]), 11);
        chk("fill4_out2", int'(dout[2]), 13);
        cycle(1'b1, 1'b1, 15, 16, 1'b1, 1, 1'b0);
        settle();
        chk("pushpop_count", int'(count), 5);
        chk("pushpop_out0", int'(dout[0]), 12);

        // Fill to full from reset, rejected push, wrap on write and read
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'h40 + 2*i, 8'h41 + 2*i, 1'b0, 0, 1'b0);
        settle();
        chk("full_count", int'(count), 8);
        chk("full_in_ready", int'(in_ready), 0);
        cycle(1'b1, 1'b1, 99, 98, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b1, 3, 1'b0);
        cycle(1'b1, 1'b1, 21, 22, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b1, 3, 1'b0);
        settle();
        chk("wrap_out0", int'(dout[0]), 8'h46);
        chk("wrap_out1", int'(dout[1]), 8'h47);
        chk("wrap_out2", int'(dout[2]), 21);

        // Flush beats same-cycle push and pop; next push lands at address 0
        cycle(1'b1, 1'b1, 23, 24, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 77, 78, 1'b1, 2, 1'b1);
        cycle(1'b1, 1'b1, 31, 32, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 33, 34, 1'b0, 0, 1'b0);
        settle();
        chk("flush_out0", int'(dout[0]), 31);
        chk("flush_out1", int'(dout[1]), 32);

        // Reset mid-operation beats a push
        cycle(1'b1, 1'b1, 35, 36, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 55, 56, 1'b1, 1, 1'b0);
        settle();
        chk("midrst_count", int'(count), 0);
        chk("midrst_out1", int'(dout[1]), 0);

        // Randomised traffic, including over-range strides and occasional flush/reset
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 24) == 0);
        end
        idle();
        idle();
        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
